fft_uart_framer: RTL

- Upstream feeder for the UART transmitter.
- Collects one full FFT result frame of NUM_WORDS words from the FFT output stream, then serialises it byte-by-byte into the transmitter through its start/done handshake.
- Frame on the wire: SYNC_BYTE, then each word MSB-byte first, in bin order 0..NUM_WORDS-1.
- Lets the host resynchronise on frame boundaries.

---
 rtl/fft_uart_pkg.sv | 23 ++
 rtl/fft_frame_buf.sv | 35 +++
 rtl/fft_uart_framer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_uart_pkg.sv
// fft_uart_pkg: shared definitions for the FFT-to-UART framer.
//   state_t           framer state encoding
//   DEFAULT_SYNC_BYTE header byte that opens every frame on the wire
//   bytes_per_frame() payload bytes in one frame (header/checksum excluded)
package fft_uart_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_HDR,
    ST_SEND,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int unsigned bytes_per_frame(input int unsigned num_words,
                                                  input int unsigned data_w);
    return num_words * (data_w / 8);
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: NUM_WORDS x DATA_W frame store, one synchronous write port
// and one asynchronous read port (maps onto distributed RAM). No reset:
// contents are undefined until written.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational)
module fft_frame_buf
  import fft_uart_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned DATA_W    = 16,
  localparam int unsigned ADDR_W   = $clog2(NUM_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [NUM_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fft_uart_framer.sv
// fft_uart_framer: collects one frame of NUM_WORDS FFT words, then feeds it
// byte-by-byte to a UART transmitter: SYNC_BYTE, then each word MSB byte
// first in bin order. Optional build macro FFT_UART_CHECKSUM_EN appends the
// XOR of all payload bytes as a trailing byte.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid, i_data       input word stream, accepted while o_ready
//   o_ready               high only while collecting (FILL)
//   o_tx_start            one-cycle start pulse to the transmitter
//   o_tx_byte             byte to send, held from start until i_tx_done
//   i_tx_busy, i_tx_done  transmitter busy level / done pulse
//   o_busy                high while a frame is being sent
//   o_frame_done          one-cycle pulse after the final byte completes
module fft_uart_framer
  import fft_uart_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned DATA_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_busy,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int unsigned BPW    = DATA_W / 8;
  localparam int unsigned BPF    = bytes_per_frame(NUM_WORDS, DATA_W);
  localparam int unsigned WORD_W = $clog2(NUM_WORDS);
  localparam int unsigned BSEL_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CNT_W  = $clog2(BPF + 1);

  state_t state_q, state_d;

  logic [WORD_W-1:0] wr_idx_q, wr_idx_d;
  logic [WORD_W-1:0] rd_word_q, rd_word_d;
  logic [BSEL_W-1:0] rd_byte_q, rd_byte_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

  logic              ready_d, tx_start_d, busy_d, frame_done_d;
  logic [7:0]        tx_byte_d;

  logic              accept;
  logic              last_payload;
  logic              frame_end;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        sel_byte;

`ifdef FFT_UART_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_sent_q, csum_sent_d;
`endif

  fft_frame_buf #(
    .NUM_WORDS (NUM_WORDS),
    .DATA_W    (DATA_W)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (accept),
    .i_waddr (wr_idx_q),
    .i_wdata (i_data),
    .i_raddr (rd_word_q),
    .o_rdata (rd_data)
  );

  // o_ready is only ever high in FILL, so it doubles as the state qualifier.
  assign accept       = i_valid && o_ready;
  assign last_payload = (byte_cnt_q == CNT_W'(BPF));

`ifdef FFT_UART_CHECKSUM_EN
  assign frame_end = csum_sent_q;
`else
  assign frame_end = last_payload;
`endif

  // Byte 0 is the most significant byte of the word.
  always_comb begin
    sel_byte = rd_data[DATA_W-1 -: 8];
    for (int unsigned b = 0; b < BPW; b++) begin
      if (rd_byte_q == BSEL_W'(b)) begin
        sel_byte = rd_data[DATA_W-1-8*b -: 8];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_FILL;
      wr_idx_q     <= '0;
      rd_word_q    <= '0;
      rd_byte_q    <= '0;
      byte_cnt_q   <= '0;
      o_ready      <= 1'b0;
      o_tx_start   <= 1'b0;
      o_tx_byte    <= 8'hFF;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
`ifdef FFT_UART_CHECKSUM_EN
      csum_q       <= '0;
      csum_sent_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_word_q    <= rd_word_d;
      rd_byte_q    <= rd_byte_d;
      byte_cnt_q   <= byte_cnt_d;
      o_ready      <= ready_d;
      o_tx_start   <= tx_start_d;
      o_tx_byte    <= tx_byte_d;
      o_busy       <= busy_d;
      o_frame_done <= frame_done_d;
`ifdef FFT_UART_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_sent_q  <= csum_sent_d;
`endif
    end
  end

  // Next state and index bookkeeping.
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_word_d  = rd_word_q;
    rd_byte_d  = rd_byte_q;
    byte_cnt_d = byte_cnt_q;
`ifdef FFT_UART_CHECKSUM_EN
    csum_d      = csum_q;
    csum_sent_d = csum_sent_q;
`endif
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (wr_idx_q == WORD_W'(NUM_WORDS - 1)) begin
            wr_idx_d = '0;
            state_d  = ST_HDR;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_HDR: begin
`ifdef FFT_UART_CHECKSUM_EN
        csum_d      = '0;
        csum_sent_d = 1'b0;
`endif
        if (!i_tx_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done coincident with our own start pulse is not legal; drop it.
        if (i_tx_done && !o_tx_start) begin
          state_d = frame_end ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          state_d = ST_WAIT;
`ifdef FFT_UART_CHECKSUM_EN
          if (last_payload) begin
            csum_sent_d = 1'b1;
          end else begin
            csum_d = csum_q ^ sel_byte;
`endif
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (rd_byte_q == BSEL_W'(BPW - 1)) begin
              rd_byte_d = '0;
              rd_word_d = rd_word_q + 1'b1;
            end else begin
              rd_byte_d = rd_byte_q + 1'b1;
            end
`ifdef FFT_UART_CHECKSUM_EN
          end
`endif
        end
      end
      ST_DONE: begin
        state_d    = ST_FILL;
        wr_idx_d   = '0;
        rd_word_d  = '0;
        rd_byte_d  = '0;
        byte_cnt_d = '0;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Registered outputs, computed one cycle ahead.
  always_comb begin
    ready_d      = (state_d == ST_FILL);
    busy_d       = (state_d inside {ST_HDR, ST_SEND, ST_WAIT, ST_GAP});
    tx_start_d   = 1'b0;
    tx_byte_d    = o_tx_byte;
    frame_done_d = 1'b0;
    case (state_q)
      ST_HDR: begin
        tx_byte_d  = SYNC_BYTE;
        tx_start_d = !i_tx_busy;
      end
      ST_SEND: begin
`ifdef FFT_UART_CHECKSUM_EN
        tx_byte_d  = last_payload ? csum_q : sel_byte;
`else
        tx_byte_d  = sel_byte;
`endif
        tx_start_d = !i_tx_busy;
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
